// File: rtl/seg_pkg.sv
// Glyph codes, segment patterns and buffer entry type shared by the 7-segment scan driver.
package seg_pkg;

  localparam logic [4:0] GLYPH_0     = 5'h00;
  localparam logic [4:0] GLYPH_1     = 5'h01;
  localparam logic [4:0] GLYPH_2     = 5'h02;
  localparam logic [4:0] GLYPH_3     = 5'h03;
  localparam logic [4:0] GLYPH_4     = 5'h04;
  localparam logic [4:0] GLYPH_5     = 5'h05;
  localparam logic [4:0] GLYPH_6     = 5'h06;
  localparam logic [4:0] GLYPH_7     = 5'h07;
  localparam logic [4:0] GLYPH_8     = 5'h08;
  localparam logic [4:0] GLYPH_9     = 5'h09;
  localparam logic [4:0] GLYPH_A     = 5'h0A;
  localparam logic [4:0] GLYPH_B     = 5'h0B;
  localparam logic [4:0] GLYPH_C     = 5'h0C;
  localparam logic [4:0] GLYPH_D     = 5'h0D;
  localparam logic [4:0] GLYPH_E     = 5'h0E;
  localparam logic [4:0] GLYPH_F     = 5'h0F;
  localparam logic [4:0] GLYPH_L     = 5'h10;
  localparam logic [4:0] GLYPH_N     = 5'h11;
  localparam logic [4:0] GLYPH_H     = 5'h12;
  localparam logic [4:0] GLYPH_S     = 5'h15;
  localparam logic [4:0] GLYPH_Y     = 5'h19;
  localparam logic [4:0] GLYPH_BLANK = 5'h1F;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEGS_OFF = 7'h7F;

  typedef struct packed {
    logic [4:0] code;
    logic       dp;
    logic       blink;
  } digit_t;

  localparam digit_t DIGIT_RESET = '{code: GLYPH_BLANK, dp: 1'b0, blink: 1'b0};

  function automatic logic [6:0] glyph_segs(input logic [4:0] code);
    logic [6:0] segs;
    segs = SEGS_OFF;
    case (code)
      GLYPH_0: segs = 7'h40;
      GLYPH_1: segs = 7'h79;
      GLYPH_2: segs = 7'h24;
      GLYPH_3: segs = 7'h30;
      GLYPH_4: segs = 7'h19;
      GLYPH_5: segs = 7'h12;
      GLYPH_6: segs = 7'h02;
      GLYPH_7: segs = 7'h78;
      GLYPH_8: segs = 7'h00;
      GLYPH_9: segs = 7'h10;
      GLYPH_A: segs = 7'h08;
      GLYPH_B: segs = 7'h03;
      GLYPH_C: segs = 7'h46;
      GLYPH_D: segs = 7'h21;
      GLYPH_E: segs = 7'h06;
      GLYPH_F: segs = 7'h0E;
      GLYPH_L: segs = 7'h47;
      GLYPH_N: segs = 7'h2B;
      GLYPH_H: segs = 7'h09;
      GLYPH_S: segs = 7'h12;
      GLYPH_Y: segs = 7'h11;
      default: segs = SEGS_OFF;
    endcase
    return segs;
  endfunction

endpackage

// File: rtl/seg_glyph_decoder.sv
// Combinational glyph code + decimal point to active-low {dp,g,f,e,d,c,b,a} pattern.
module seg_glyph_decoder
  import seg_pkg::*;
(
  input  logic [4:0] code,
  input  logic       dp,
  output logic [7:0] pattern
);

  always_comb begin
    pattern = {~dp, glyph_segs(code)};
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: shadow/active glyph buffers with frame-synchronous
// commit, brightness PWM, per-digit blink, anti-ghost guard and selectable output polarity.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_LOG2    = 14,
  parameter int BRIGHT_W     = 3,
  parameter int GUARD        = 64,
  parameter int BLINK_FRAMES = 32,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit SEL_ACT_LOW  = 1'b1,
  localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [4:0]            wr_code,
  input  logic                  wr_dp,
  input  logic                  wr_blink,
  input  logic                  commit,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic                  blank_all,
  output logic                  commit_pending,
  output logic                  frame_start,
  output logic [7:0]            seg_data,
  output logic [NUM_DIGITS-1:0] seg_sel
);

  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IDX_W-1:0]      LAST_DIG = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0]      LAST_FRM = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [SCAN_LOG2-1:0]  GUARD_C  = SCAN_LOG2'(GUARD);
  localparam logic [7:0]            SEG_IDLE = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE = SEL_ACT_LOW ? '1 : '0;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  logic [SCAN_LOG2-1:0]  div_cnt;
  logic [IDX_W-1:0]      dig_idx;
  logic [FRM_W-1:0]      frm_cnt;
  logic                  blink_ph;
  logic [0:0]            state;
  digit_t                shadow [NUM_DIGITS];
  digit_t                active [NUM_DIGITS];

  logic                  frame_end;
  digit_t                cur;
  logic [7:0]            pattern;
  logic [BRIGHT_W-1:0]   level;
  logic                  digit_on;
  logic [NUM_DIGITS-1:0] sel_hot;

  assign frame_end      = (&div_cnt) && (dig_idx == LAST_DIG);
  assign commit_pending = (state == ST_PEND);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      dig_idx  <= '0;
      frm_cnt  <= '0;
      blink_ph <= 1'b0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      if (&div_cnt) begin
        dig_idx <= (dig_idx == LAST_DIG) ? '0 : dig_idx + 1'b1;
      end
      if (frame_end) begin
        if (frm_cnt == LAST_FRM) begin
          frm_cnt  <= '0;
          blink_ph <= ~blink_ph;
        end else begin
          frm_cnt <= frm_cnt + 1'b1;
        end
      end
    end
  end

  // Shadow write and the frame-end copy share one edge; the copy sees the pre-write shadow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= DIGIT_RESET;
        active[i] <= DIGIT_RESET;
      end
    end else begin
      if (wr_en && (int'(wr_idx) < NUM_DIGITS)) begin
        shadow[wr_idx] <= '{code: wr_code, dp: wr_dp, blink: wr_blink};
      end
      if ((state == ST_PEND) && frame_end) begin
        active <= shadow;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (commit) state <= ST_PEND;
        ST_PEND: if (frame_end && !commit) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cur = active[dig_idx];

  seg_glyph_decoder u_glyph_decoder (
    .code    (cur.code),
    .dp      (cur.dp),
    .pattern (pattern)
  );

  // A digit with no lit segment is not selected at all, so blank positions draw no drive.
  always_comb begin
    level    = div_cnt[SCAN_LOG2-1 -: BRIGHT_W];
    sel_hot  = NUM_DIGITS'(1) << dig_idx;
    digit_on = (div_cnt >= GUARD_C) && (level <= brightness) && !blank_all
               && !(cur.blink && blink_ph) && (pattern != 8'hFF);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_data    <= SEG_IDLE;
      seg_sel     <= SEL_IDLE;
      frame_start <= 1'b0;
    end else begin
      seg_data    <= digit_on ? (SEG_ACT_LOW ? pattern : ~pattern) : SEG_IDLE;
      seg_sel     <= digit_on ? (SEL_ACT_LOW ? ~sel_hot : sel_hot) : SEL_IDLE;
      frame_start <= (div_cnt == '0) && (dig_idx == '0);
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (4 digits, 16-clock slots, 2-bit brightness).
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic [4:0] wr_code;
  logic       wr_dp;
  logic       wr_blink;
  logic       commit;
  logic [1:0] brightness;
  logic       blank_all;
  logic       commit_pending;
  logic       frame_start;
  logic [7:0] seg_data;
  logic [3:0] seg_sel;

  int checks = 0;
  int errors = 0;
  int ts;
  logic [7:0] exp_pat [4];
  logic       exp_blk [4];

  seg_scan_driver #(
    .NUM_DIGITS   (4),
    .SCAN_LOG2    (4),
    .BRIGHT_W     (2),
    .GUARD        (1),
    .BLINK_FRAMES (2),
    .SEG_ACT_LOW  (1'b1),
    .SEL_ACT_LOW  (1'b1)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .wr_en          (wr_en),
    .wr_idx         (wr_idx),
    .wr_code        (wr_code),
    .wr_dp          (wr_dp),
    .wr_blink       (wr_blink),
    .commit         (commit),
    .brightness     (brightness),
    .blank_all      (blank_all),
    .commit_pending (commit_pending),
    .frame_start    (frame_start),
    .seg_data       (seg_data),
    .seg_sel        (seg_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // One clock; outputs after edge ts reflect counter state ts (counted from reset release).
  task automatic step();
    int div, dig, frm, ph;
    logic on;
    logic [3:0] sel_e;
    @(posedge clk);
    #1;
    ts++;
    div = ts % 16;
    dig = (ts / 16) % 4;
    frm = ts / 64;
    ph  = (frm / 2) % 2;
    on  = (div >= 1) && ((div / 4) <= int'(brightness)) && !blank_all
          && !(exp_blk[dig] && ph == 1) && (exp_pat[dig] != 8'hFF);
    sel_e = 4'hF;
    if (on) sel_e[dig] = 1'b0;
    check($sformatf("seg_sel@%0d", ts), 32'(seg_sel), 32'(sel_e));
    check($sformatf("seg_data@%0d", ts), 32'(seg_data), on ? 32'(exp_pat[dig]) : 32'hFF);
    check($sformatf("frame_start@%0d", ts), 32'(frame_start), (ts % 64 == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic write_digit(input logic [1:0] idx, input logic [4:0] code,
                             input logic dp, input logic blink);
    wr_en = 1'b1; wr_idx = idx; wr_code = code; wr_dp = dp; wr_blink = blink;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic clear_expect();
    for (int i = 0; i < 4; i++) begin
      exp_pat[i] = 8'hFF;
      exp_blk[i] = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_code = '0; wr_dp = 1'b0;
    wr_blink = 1'b0; commit = 1'b0; brightness = 2'd3; blank_all = 1'b0;
    clear_expect();
    repeat (2) @(posedge clk);
    #1;
    check("rst_seg_data", 32'(seg_data), 32'hFF);
    check("rst_seg_sel", 32'(seg_sel), 32'hF);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_pending", 32'(commit_pending), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ts = -1;

    // Two frames of blank digits
    run(128);

    // Frame 2: write 5 and C. and commit mid-frame; frame 3 shows them
    run(20);
    write_digit(2'd0, 5'h05, 1'b0, 1'b0);
    write_digit(2'd1, 5'h0C, 1'b1, 1'b0);
    do_commit();
    check("pend_after_commit", 32'(commit_pending), 32'd1);
    run(40);
    check("pend_before_end", 32'(commit_pending), 32'd1);
    step();
    check("pend_after_end", 32'(commit_pending), 32'd0);
    exp_pat[0] = 8'h92;
    exp_pat[1] = 8'h46;
    run(64);

    // Brightness and blank_all, one frame each
    brightness = 2'd1; run(64);
    brightness = 2'd0; run(64);
    blank_all  = 1'b1; run(64);
    blank_all  = 1'b0; brightness = 2'd3;

    // Frame 7: blinking 3 on digit 2, visible from frame 8
    write_digit(2'd2, 5'h03, 1'b0, 1'b1);
    do_commit();
    run(62);
    exp_pat[2] = 8'hB0;
    exp_blk[2] = 1'b1;
    run(256);

    // Write + commit on the frame_end cycle of frame 12
    run(63);
    wr_en = 1'b1; wr_idx = 2'd0; wr_code = 5'h07; wr_dp = 1'b0; wr_blink = 1'b0;
    commit = 1'b1;
    step();
    wr_en = 1'b0; commit = 1'b0;
    check("pend_rearm", 32'(commit_pending), 32'd1);
    run(64);
    check("pend_rearm_done", 32'(commit_pending), 32'd0);
    exp_pat[0] = 8'hF8;
    run(64);

    // Asynchronous reset mid-slot with a commit pending
    write_digit(2'd0, 5'h08, 1'b0, 1'b0);
    do_commit();
    check("pend_before_reset", 32'(commit_pending), 32'd1);
    run(20);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_seg_data", 32'(seg_data), 32'hFF);
    check("async_seg_sel", 32'(seg_sel), 32'hF);
    check("async_pending", 32'(commit_pending), 32'd0);
    check("async_frame_start", 32'(frame_start), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ts = -1;
    clear_expect();
    run(64);
    check("pend_after_reset", 32'(commit_pending), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
